// File: rtl/udp_oe_tx_sched.sv
// Round-robin packet scheduler for the UDP offload engine TX path: header phase, then one packet of payload.
// Optional packet counter enabled by defining UDPOE_TX_SCHED_STATS_EN.
module udp_oe_tx_sched #(
  parameter int NUM_CHAN = 4,
  parameter int CNT_W    = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CHAN-1:0]       chan_en,
  input  logic [NUM_CHAN*CNT_W-1:0] chan_words,
  input  logic [15:0]               payload_bytes,
  output logic                      hdr_start,
  output logic [1:0]                hdr_chan,
  input  logic                      hdr_done,
  output logic [NUM_CHAN-1:0]       fifo_rd,
  output logic                      tx_valid,
  output logic                      tx_last,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic [31:0]               pkts_sent
);

  localparam int          CMP_W = (CNT_W > 14) ? CNT_W : 14;
  localparam int unsigned NC    = NUM_CHAN;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_GAP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  grant, last_grant, sel;
  logic        hdr_first;
  logic [13:0] rem, words;
  logic [16:0] bytes_rnd;
  logic [3:0]  elig, rd4;
  logic        any_elig;

  always_comb begin
    bytes_rnd = {1'b0, payload_bytes} + 17'd7;
    words     = (payload_bytes == 16'd0) ? 14'd2 : bytes_rnd[16:3];
  end

  // Eligibility padded to 4 bits so the 2-bit channel index always selects exactly.
  for (genvar g = 0; g < 4; g++) begin : g_elig
    if (g < NUM_CHAN) begin : g_on
      assign elig[g] = chan_en[g] &&
                       (CMP_W'(chan_words[g*CNT_W +: CNT_W]) >= CMP_W'(words));
    end else begin : g_off
      assign elig[g] = 1'b0;
    end
  end

  always_comb begin
    sel      = last_grant;
    any_elig = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!any_elig && elig[2'((32'(last_grant) + 32'd1 + i) % NC)]) begin
        sel      = 2'((32'(last_grant) + 32'd1 + i) % NC);
        any_elig = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= 2'(NUM_CHAN - 1);
      rem        <= '0;
      hdr_first  <= 1'b0;
    end else begin
      state     <= state_nxt;
      hdr_first <= 1'b0;
      if (state == S_IDLE && any_elig) begin
        grant      <= sel;
        last_grant <= sel;
        rem        <= words;
        hdr_first  <= 1'b1;
      end else if (state == S_PAY && tx_ready) begin
        rem <= rem - 14'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (any_elig) state_nxt = S_HDR;
      S_HDR:  if (!hdr_first && hdr_done) state_nxt = S_PAY;
      S_PAY:  if (tx_ready && rem == 14'd1) state_nxt = S_GAP;
      S_GAP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    hdr_start = (state == S_HDR) && hdr_first;
    busy      = (state != S_IDLE);
    tx_valid  = (state == S_PAY);
    tx_last   = tx_valid && (rem == 14'd1);
    hdr_chan  = grant;
    rd4       = '0;
    if (tx_valid && tx_ready) rd4[grant] = 1'b1;
    fifo_rd   = rd4[NUM_CHAN-1:0];
  end

`ifdef UDPOE_TX_SCHED_STATS_EN
  logic [31:0] pkt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pkt_cnt <= '0;
    else if (tx_valid && tx_ready && tx_last) pkt_cnt <= pkt_cnt + 32'd1;
  end

  assign pkts_sent = pkt_cnt;
`else
  assign pkts_sent = '0;
`endif

endmodule

// File: tb/tb_udp_oe_tx_sched.sv
// Self-checking bench for udp_oe_tx_sched: vector table of packet scenarios plus hand-written corner cases,
// with an expected-grant scoreboard checked beat by beat.
module tb_udp_oe_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  chan_en = '0;
  logic [47:0] chan_words = '0;
  logic [15:0] payload_bytes = 16'd16;
  logic        hdr_start;
  logic [1:0]  hdr_chan;
  logic        hdr_done = 1'b0;
  logic [3:0]  fifo_rd;
  logic        tx_valid, tx_last;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic [31:0] pkts_sent;

  udp_oe_tx_sched #(.NUM_CHAN(4), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .chan_en(chan_en), .chan_words(chan_words),
    .payload_bytes(payload_bytes), .hdr_start(hdr_start), .hdr_chan(hdr_chan),
    .hdr_done(hdr_done), .fifo_rd(fifo_rd), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .busy(busy), .pkts_sent(pkts_sent)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] ch; int words; } grant_t;
  typedef struct {
    logic [3:0]  en;
    logic [47:0] lv;
    logic [15:0] pb;
    int          n;
    logic [9:0]  seq;
    int          words;
  } vec_t;

  grant_t     exp_q[$];
  int         errors = 0, checks = 0;
  int         hstarts = 0, beats = 0, rd_pulses = 0, cyc = 0;
  int         rem_beats = 0, cur_words = 0, t_start = 0, t_prev = 0;
  logic [1:0] cur_ch = '0;
  logic       want_lat = 1'b0, prev_valid = 1'b0, period_chk = 1'b0, hdr_force = 1'b0;
  logic       prev_stall = 1'b0, prev_last = 1'b0;
  logic [1:0] prev_ch = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard/monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (hdr_start) begin
        hstarts++;
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(hdr_chan), 32'hFFFF);
        end else begin
          grant_t e;
          e = exp_q.pop_front();
          chk("grant_chan", 32'(hdr_chan), 32'(e.ch));
          chk("prev_pkt_done", 32'(rem_beats), 0);
          if (period_chk && prev_valid) chk("pkt_period", 32'(cyc - t_prev), 32'(cur_words + 4));
          cur_ch = e.ch; rem_beats = e.words; cur_words = e.words;
          t_start = cyc; t_prev = cyc; prev_valid = 1'b1; want_lat = 1'b1;
        end
      end
      if (tx_valid && want_lat) begin
        chk("hdr_to_valid", 32'(cyc - t_start), 2);
        want_lat = 1'b0;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(tx_valid), 1);
        chk("stall_last", 32'(tx_last), 32'(prev_last));
        chk("stall_chan", 32'(hdr_chan), 32'(prev_ch));
      end
      if (fifo_rd != 4'd0) rd_pulses++;
      if (tx_valid && tx_ready) begin
        beats++;
        chk("beat_chan", 32'(hdr_chan), 32'(cur_ch));
        chk("beat_last", 32'(tx_last), 32'(rem_beats == 1));
        chk("beat_rd", 32'(fifo_rd), 32'(4'b0001 << cur_ch));
        chk("beat_busy", 32'(busy), 1);
        rem_beats--;
      end else if (fifo_rd != 4'd0) begin
        chk("stray_rd", 32'(fifo_rd), 0);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_last  = tx_last;
      prev_ch    = hdr_chan;
    end
  end

  // Header generator model: hdr_done one cycle after hdr_start unless held high by a test.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && hdr_start && !hdr_force) begin
        @(posedge clk); #1 hdr_done = 1'b1;
        @(posedge clk); #1 if (!hdr_force) hdr_done = 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    hstarts = 0; beats = 0; rd_pulses = 0; rem_beats = 0;
    want_lat = 1'b0; prev_valid = 1'b0; prev_stall = 1'b0;
    #1;
    chk("rst_hdr_start", 32'(hdr_start), 0);
    chk("rst_fifo_rd", 32'(fifo_rd), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_last", 32'(tx_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hdr_chan", 32'(hdr_chan), 0);
    chk("rst_pkts_sent", pkts_sent, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_grants(input int target, input int budget);
    int n = 0;
    while (hstarts < target && n < budget) begin @(posedge clk); #1; n++; end
    if (hstarts < target) chk("grant_timeout", 32'(hstarts), 32'(target));
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beats < target && n < budget) begin @(posedge clk); #1; n++; end
    if (beats < target) chk("beat_timeout", 32'(beats), 32'(target));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || rem_beats != 0 || exp_q.size() != 0) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (n >= budget) chk("idle_timeout", 32'(busy), 0);
  endtask

  function automatic logic [31:0] exp_pkts(input int n);
`ifdef UDPOE_TX_SCHED_STATS_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  vec_t vt[6];

  initial begin
    vt[0] = '{en: 4'b0001, lv: {12'd0, 12'd0, 12'd0, 12'd2},     pb: 16'd16, n: 1, seq: 10'b00_00_00_00_00, words: 2};
    vt[1] = '{en: 4'b1111, lv: {12'd100, 12'd100, 12'd100, 12'd100}, pb: 16'd64, n: 5, seq: 10'b00_11_10_01_00, words: 8};
    vt[2] = '{en: 4'b0001, lv: {12'd0, 12'd0, 12'd0, 12'd2},     pb: 16'd9,  n: 1, seq: 10'b00_00_00_00_00, words: 2};
    vt[3] = '{en: 4'b0100, lv: {12'd0, 12'd2, 12'd0, 12'd0},     pb: 16'd0,  n: 1, seq: 10'b00_00_00_00_10, words: 2};
    vt[4] = '{en: 4'b1010, lv: {12'd50, 12'd50, 12'd50, 12'd50}, pb: 16'd17, n: 3, seq: 10'b00_00_01_11_01, words: 3};
    vt[5] = '{en: 4'b0011, lv: {12'd0, 12'd0, 12'd7, 12'd8},     pb: 16'd64, n: 2, seq: 10'b00_00_00_00_00, words: 8};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      period_chk = 1'b1;
      payload_bytes = vt[v].pb;
      chan_words    = vt[v].lv;
      for (int i = 0; i < vt[v].n; i++) begin
        grant_t g;
        g.ch = vt[v].seq[2*i +: 2];
        g.words = vt[v].words;
        exp_q.push_back(g);
      end
      chan_en = vt[v].en;
      wait_grants(vt[v].n, 400);
      chan_en = '0;
      wait_idle(400);
      repeat (10) @(posedge clk);
      #1;
      chk("vec_grants", 32'(hstarts), 32'(vt[v].n));
      chk("vec_beats", 32'(beats), 32'(vt[v].n * vt[v].words));
      chk("vec_pkts_sent", pkts_sent, exp_pkts(vt[v].n));
    end
    period_chk = 1'b0;

    // Threshold: 0 bytes means 2 words, so a 1-word fill must not be granted.
    do_reset();
    payload_bytes = 16'd0;
    chan_words = {12'd0, 12'd0, 12'd0, 12'd1};
    chan_en = 4'b0001;
    repeat (20) @(posedge clk);
    #1;
    chk("thresh_no_grant", 32'(hstarts), 0);
    chk("thresh_idle", 32'(busy), 0);
    exp_q.push_back('{ch: 2'd0, words: 2});
    chan_words = {12'd0, 12'd0, 12'd0, 12'd2};
    wait_grants(1, 50);
    chan_en = '0;
    wait_idle(100);
    chk("thresh_beats", 32'(beats), 2);

    // Backpressure: tx_ready toggles every cycle across a 64-byte packet.
    do_reset();
    payload_bytes = 16'd64;
    chan_words = {12'd0, 12'd0, 12'd0, 12'd100};
    exp_q.push_back('{ch: 2'd0, words: 8});
    chan_en = 4'b0001;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      tx_ready = ~tx_ready;
      if (hstarts >= 1) chan_en = '0;
      if (hstarts >= 1 && !busy && rem_beats == 0) break;
    end
    tx_ready = 1'b1;
    wait_idle(100);
    chk("bp_grants", 32'(hstarts), 1);
    chk("bp_rd_pulses", 32'(rd_pulses), 8);

    // chan_en dropped mid-PAY: packet completes, no further grant.
    do_reset();
    exp_q.push_back('{ch: 2'd0, words: 8});
    chan_en = 4'b0001;
    wait_beats(3, 100);
    chan_en = '0;
    wait_idle(100);
    repeat (20) @(posedge clk);
    #1;
    chk("drop_grants", 32'(hstarts), 1);
    chk("drop_beats", 32'(beats), 8);

    // hdr_done held high: must be ignored in the hdr_start cycle and outside HDR.
    do_reset();
    hdr_force = 1'b1;
    hdr_done = 1'b1;
    payload_bytes = 16'd16;
    chan_words = {12'd0, 12'd0, 12'd0, 12'd2};
    exp_q.push_back('{ch: 2'd0, words: 2});
    chan_en = 4'b0001;
    wait_grants(1, 50);
    chan_en = '0;
    wait_idle(100);
    hdr_done = 1'b0;
    hdr_force = 1'b0;
    chk("force_beats", 32'(beats), 2);

    // Reset mid-PAY: outputs clear at once, round-robin restarts at channel 0.
    do_reset();
    payload_bytes = 16'd64;
    chan_words = {12'd0, 12'd0, 12'd100, 12'd100};
    exp_q.push_back('{ch: 2'd0, words: 8});
    chan_en = 4'b0011;
    wait_beats(3, 100);
    chk("mid_pay_valid", 32'(tx_valid), 1);
    do_reset();
    exp_q.push_back('{ch: 2'd0, words: 8});
    wait_grants(1, 50);
    chan_en = '0;
    wait_idle(100);
    chk("post_rst_beats", 32'(beats), 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udp_oe_tx_sched.md
# udp_oe_tx_sched

Packet-level transmit scheduler for the UDP offload engine. It arbitrates round-robin among the per-channel TX DCFIFOs and grants one channel at a time access to the shared header generator and HSSI TX datapath. For each packet it sequences a header phase, then exactly one packet's worth of 64-bit payload words, so each UDP packet leaves as one contiguous burst. It sits between the channel TX DCFIFO read sides and the Ethernet/IPv4/UDP framing stage.

## Interface
Parameters:
- NUM_CHAN, 4: number of channels; valid range 1–4.
- CNT_W, 12: width of each FIFO fill-level input; sized for a 2048-word DCFIFO.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- chan_en  in  NUM_CHAN  per-channel enable from the misc-control CSR.
- chan_words  in  NUM_CHAN*CNT_W  per-channel TX FIFO fill level in words. Channel c occupies bits [c*CNT_W +: CNT_W].
- payload_bytes  in  16  payload bytes per packet, from CSR_PAYLOAD_PER_PACKET.
- hdr_start  out  1  one-cycle pulse requesting header generation.
- hdr_chan  out  2  channel being served; valid while busy.
- hdr_done  in  1  header generator has emitted the full header.
- fifo_rd  out  NUM_CHAN  one-hot read-acknowledge to the show-ahead FIFOs.
- tx_valid  out  1  payload word valid.
- tx_last  out  1  final payload word of the packet.
- tx_ready  in  1  downstream accepts a word.
- busy  out  1  high in every state except IDLE.
- pkts_sent  out  32  total packets completed (see Configuration).

## Operation
- Packet size: words = (payload_bytes + 7) >> 3, giving a 14-bit result. If payload_bytes is 0, words = 2, which is the 16-byte default.
- words is latched at grant. CSR changes mid-packet take effect on the next packet.
- A channel is eligible when chan_en[c] = 1 and chan_words[c] >= words, evaluated against the live value.
- Round-robin: the search starts at last_grant+1 modulo NUM_CHAN. last_grant resets to NUM_CHAN-1, so channel 0 wins first.
- State machine:
  - IDLE: if any channel is eligible, register the grant, load rem = words, pulse hdr_start, and go to HDR.
  - HDR: wait for hdr_done. hdr_done is ignored in the hdr_start cycle. On hdr_done, go to PAY.
  - PAY: tx_valid = 1 and fifo_rd[grant] = tx_ready. On each accepted beat, rem decrements. tx_last = (rem == 1). The beat accepted with tx_last set moves the FSM to GAP.
  - GAP: one idle cycle, then IDLE.
- chan_en deasserting mid-packet does not abort. The packet completes, and the channel stays ineligible afterward.
- hdr_done asserted in IDLE, PAY or GAP is ignored.
- fifo_rd is only ever asserted for the granted channel and only in PAY. The scheduler never reads more words than it checked for at grant.

## Timing
- Reset values: hdr_start = 0, fifo_rd = 0, tx_valid = 0, tx_last = 0, busy = 0, hdr_chan = 0, pkts_sent = 0, state = IDLE.
- Grant latency: eligibility seen in cycle N gives hdr_start and busy high in cycle N+1.
- hdr_done sampled in cycle M puts tx_valid high in cycle M+1.
- tx_valid, tx_last and hdr_chan are registered and stay stable while tx_ready = 0.
- Minimum packet period is words + 4 cycles: grant, HDR with same-cycle hdr_done, PAY, GAP.
- Back-to-back packets from the same channel are allowed if it is still eligible in IDLE and no other channel wins the round-robin.
- Asserting rst_n low mid-packet immediately forces every output to its reset value. Any partially read packet is discarded upstream by the channel reset.

## Configuration
- UDPOE_TX_SCHED_STATS_EN:
  - Defined: pkts_sent increments on every final accepted beat and wraps at 2^32.
  - Undefined: pkts_sent is tied to 0 and no counter logic is generated.

## Test plan
- Single channel: payload_bytes = 16, chan_words[0] = 2, chan_en = 0001. Expect one hdr_start, then 2 beats with tx_last on the second, then busy low after GAP.
- Round-robin: all four channels enabled with chan_words = 100 and payload_bytes = 64. Expect grants in the order 0, 1, 2, 3, 0, each packet 8 beats.
- Backpressure: tx_ready toggles 1/0 during a 64-byte packet. Expect exactly 8 fifo_rd pulses, with outputs held stable while tx_ready = 0.
- Thresholds: payload_bytes = 0 with chan_words = 1 gives no grant; raising chan_words to 2 gives a 2-beat packet. Separately, payload_bytes = 9 gives a 2-beat packet.
- Disruptions: clear chan_en mid-packet and expect the packet to complete and no further grant. Separately, assert rst_n low mid-PAY and expect all outputs 0 in the same cycle and a grant to channel 0 after release.
- Stats: with UDPOE_TX_SCHED_STATS_EN defined, 5 packets give pkts_sent = 5. With it undefined, pkts_sent stays 0.
